bus_router: RTL and testbench
=============================

# bus_router

Parametrised single-master, N-slave bus router with registered decode, a full request/ready handshake, and bus-error reporting. It replaces the flat combinational address-compare/mux chain in the SoC top level. It sits between the CPU-side `Bus` arbiter output and the peripheral/memory slaves. It latches each transaction, routes it to exactly one slave (or to none, for an error), and returns registered read data.

## Interface
- `SLAVES`, 8: number of slave ports, 1..16.
- `DATA_W`, 32: data width.
- `SLAVE_BASE`, {SLAVES{32'h0}}: packed `SLAVES*32` base addresses; slave k occupies bits [k*32+:32].
- `SLAVE_MASK`, {SLAVES{32'hFFFF0000}}: packed `SLAVES*32` masks; slave k hits when `(addr & mask_k) == base_k`.
- `TIMEOUT`, 1023: cycles without slave ready before an error response, 1..65535.

Ports:
- `i_clock`  in  1  sole clock; all state on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_request`  in  1  master request; held high until `o_ready`.
- `i_rw`  in  1  1 = write, 0 = read.
- `i_address`  in  32  byte address.
- `i_wdata`  in  DATA_W  write data.
- `o_rdata`  out  DATA_W  registered read data.
- `o_ready`  out  1  transaction complete.
- `o_error`  out  1  valid with `o_ready`: unmapped address or timeout.
- `o_slave_enable`  out  SLAVES  one-hot slave select.
- `o_slave_rw`  out  1  latched rw.
- `o_slave_address`  out  32  latched address minus the selected slave's base.
- `o_slave_wdata`  out  DATA_W  latched wdata.
- `i_slave_rdata`  in  SLAVES*DATA_W  packed slave read data.
- `i_slave_ready`  in  SLAVES  per-slave ready.

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE, `i_request`=1:
  - Latch address, rw and wdata.
  - Decode by priority; the lowest matching index wins.
  - If any slave matches: set the one-hot enable and go to ACCESS.
  - If no slave matches: set `o_error`=1, `o_rdata`=0, and go to RESPOND.
- ACCESS:
  - Hold `o_slave_enable` and the latched outputs constant.
  - Count cycles in the timeout counter.
  - Selected `i_slave_ready`=1: capture the selected slave's rdata into `o_rdata` (writes also capture it; the value is don't-care), clear enable, clear `o_error`, go to RESPOND.
  - Counter reaches `TIMEOUT`: clear enable, set `o_error`=1, set `o_rdata`=0, go to RESPOND.
  - Ready and timeout on the same cycle: ready wins.
- RESPOND:
  - `o_ready`=1 until the master drops `i_request`, then return to IDLE.
  - `o_rdata` and `o_error` stay stable throughout RESPOND.
- The ready input of non-selected slaves is ignored.
- `i_address`, `i_rw` and `i_wdata` are ignored outside IDLE.
- Overlapping windows are legal; priority resolves them.
- Offset arithmetic is modulo 2^32.
- Timeout counter: 16 bits, cleared on entry to ACCESS, saturating.

## Timing
- Reset (async assert, synchronous release): state IDLE.
  - Outputs 0: `o_ready`, `o_error`, `o_rdata`, `o_slave_enable`, `o_slave_rw`, `o_slave_address`, `o_slave_wdata`, counter.
- Request sampled in IDLE at edge T:
  - `o_slave_enable` is valid after T.
  - A slave ready at the T+1 edge gives `o_ready`=1 after T+1, so minimum latency is 2 cycles.
- Unmapped request: `o_ready`=1 and `o_error`=1 after T, so latency is 1 cycle.
- Timeout: `o_ready` rises after T+TIMEOUT.
- Request dropped at edge R while in RESPOND:
  - `o_ready`=0 after R.
  - A new request is accepted at R+1 at the earliest.
- Reset mid-transaction: abort immediately, enable drops asynchronously, no response is issued.

## Configuration
- `BUS_ROUTER_TIMEOUT_EN`
  - Defined: timeout counter and timeout error present, as above.
  - Undefined: no counter; ACCESS waits indefinitely for slave ready; `o_error` is asserted only for unmapped addresses; `TIMEOUT` is ignored.

## Test plan
- Read, SLAVES=4, slave1 base 0x00010000 mask 0xFFFF0000, ready after 3 cycles, rdata 0xDEADBEEF: address 0x00010024 -> `o_slave_enable`=4'b0010, offset 0x24, `o_ready` 4 cycles after the request edge, `o_rdata`=0xDEADBEEF, `o_error`=0.
- Write of 0x12345678 to 0x50000010, slave ready immediately -> slave sees rw=1 and wdata 0x12345678; `o_ready` after 2 cycles; `o_error`=0.
- Read at 0x30000000, unmapped -> no enable asserted; `o_ready`=1 and `o_error`=1 after 1 cycle; `o_rdata`=0.
- TIMEOUT=8 with `BUS_ROUTER_TIMEOUT_EN` defined, slave never ready:
  - `o_error`=1 and `o_ready` at cycle 8.
  - With the macro undefined, the bench sees no `o_ready` for 100 cycles.
- Slaves 0 and 2 both match 0x00000100 -> slave 0 is selected; slave 2 ready pulses are ignored.
- `i_reset_n` low during ACCESS -> all outputs 0 immediately; the next request after release completes normally.

Source files
------------

// File: rtl/bus_router.sv
// bus_router: single-master, N-slave bus router with registered decode.
//
// A master request is latched in IDLE, decoded against per-slave base/mask
// windows (lowest matching index wins) and forwarded to exactly one slave.
// The selected slave's ready ends the access; read data is registered and
// presented with o_ready until the master drops i_request. Unmapped
// addresses answer in one cycle with o_error.
//
// Optional feature macro: BUS_ROUTER_TIMEOUT_EN
//   defined   - 16-bit saturating access counter; after TIMEOUT cycles
//               without slave ready the access ends with o_error.
//   undefined - no counter; ACCESS waits for slave ready indefinitely.
//
// Ports:
//   i_clock, i_reset_n          clock, asynchronous active-low reset
//   i_request/i_rw/i_address/i_wdata  master request (held until o_ready)
//   o_rdata/o_ready/o_error     registered response to master
//   o_slave_enable              one-hot slave select
//   o_slave_rw/o_slave_address/o_slave_wdata  latched request to slave;
//                               address is relative to the slave's base
//   i_slave_rdata/i_slave_ready packed per-slave read data and ready
module bus_router #(
  parameter int unsigned               SLAVES     = 8,
  parameter int unsigned               DATA_W     = 32,
  parameter logic [SLAVES*32-1:0]      SLAVE_BASE = {SLAVES{32'h0}},
  parameter logic [SLAVES*32-1:0]      SLAVE_MASK = {SLAVES{32'hFFFF0000}},
  parameter int unsigned               TIMEOUT    = 1023
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_request,
  input  logic                     i_rw,
  input  logic [31:0]              i_address,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_ready,
  output logic                     o_error,
  output logic [SLAVES-1:0]        o_slave_enable,
  output logic                     o_slave_rw,
  output logic [31:0]              o_slave_address,
  output logic [DATA_W-1:0]        o_slave_wdata,
  input  logic [SLAVES*DATA_W-1:0] i_slave_rdata,
  input  logic [SLAVES-1:0]        i_slave_ready
);

  if (SLAVES < 1 || SLAVES > 16) begin : g_bad_slaves
    $error("bus_router: SLAVES must be in 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bus_router: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

  state_e              r_state;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ready;
  logic                r_error;
  logic [SLAVES-1:0]   r_enable;
  logic                r_rw;
  logic [31:0]         r_address;
  logic [DATA_W-1:0]   r_wdata;

`ifdef BUS_ROUTER_TIMEOUT_EN
  // The access times out on the edge where the counter already holds TIMEOUT-1,
  // so o_ready rises exactly TIMEOUT edges after the request was accepted.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  logic [15:0]         r_count;
`endif

  // Address decode: iterate downwards so the lowest matching index is the
  // last assignment and therefore wins.
  logic [SLAVES-1:0]   w_sel_onehot;
  logic [31:0]         w_sel_base;
  logic                w_any_hit;

  always_comb begin
    w_sel_onehot = '0;
    w_sel_base   = '0;
    w_any_hit    = 1'b0;
    for (int k = int'(SLAVES) - 1; k >= 0; k--) begin
      if ((i_address & SLAVE_MASK[k*32 +: 32]) == SLAVE_BASE[k*32 +: 32]) begin
        w_sel_onehot    = '0;
        w_sel_onehot[k] = 1'b1;
        w_sel_base      = SLAVE_BASE[k*32 +: 32];
        w_any_hit       = 1'b1;
      end
    end
  end

  // Response path is qualified by the latched enable, so ready/rdata from
  // non-selected slaves never reach the master.
  logic                w_sel_ready;
  logic [DATA_W-1:0]   w_sel_rdata;

  always_comb begin
    w_sel_ready = |(i_slave_ready & r_enable);
    w_sel_rdata = '0;
    for (int k = 0; k < int'(SLAVES); k++) begin
      if (r_enable[k]) begin
        w_sel_rdata = i_slave_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= StIdle;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
      r_enable  <= '0;
      r_rw      <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
`ifdef BUS_ROUTER_TIMEOUT_EN
      r_count   <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_request) begin
            r_rw    <= i_rw;
            r_wdata <= i_wdata;
`ifdef BUS_ROUTER_TIMEOUT_EN
            r_count <= '0;
`endif
            if (w_any_hit) begin
              r_enable  <= w_sel_onehot;
              // Offset wraps modulo 2^32 for windows whose mask leaves base bits free.
              r_address <= i_address - w_sel_base;
              r_state   <= StAccess;
            end else begin
              // No slave to offset against: keep the raw address.
              r_address <= i_address;
              r_error   <= 1'b1;
              r_rdata   <= '0;
              r_ready   <= 1'b1;
              r_state   <= StRespond;
            end
          end
        end

        StAccess: begin
          if (w_sel_ready) begin
            r_rdata  <= w_sel_rdata;
            r_error  <= 1'b0;
            r_enable <= '0;
            r_ready  <= 1'b1;
            r_state  <= StRespond;
          end
`ifdef BUS_ROUTER_TIMEOUT_EN
          else if (r_count == TimeoutLast) begin
            r_rdata  <= '0;
            r_error  <= 1'b1;
            r_enable <= '0;
            r_ready  <= 1'b1;
            r_state  <= StRespond;
          end else if (r_count != 16'hFFFF) begin
            r_count <= r_count + 16'd1;
          end
`endif
        end

        StRespond: begin
          if (!i_request) begin
            r_ready <= 1'b0;
            r_state <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rdata         = r_rdata;
  assign o_ready         = r_ready;
  assign o_error         = r_error;
  assign o_slave_enable  = r_enable;
  assign o_slave_rw      = r_rw;
  assign o_slave_address = r_address;
  assign o_slave_wdata   = r_wdata;

endmodule

// File: tb/tb_bus_router.sv
module tb_bus_router;

  localparam int NS  = 4;
  localparam int TMO = 8;

  localparam logic [NS*32-1:0] BASES = {32'h50000000, 32'h00000000, 32'h00010000, 32'h00000000};
  localparam logic [NS*32-1:0] MASKS = {32'hF0000000, 32'hFF000000, 32'hFFFF0000, 32'hFFFF0000};

  logic              clk = 1'b0;
  logic              i_reset_n;
  logic              i_request;
  logic              i_rw;
  logic [31:0]       i_address;
  logic [31:0]       i_wdata;
  logic [31:0]       o_rdata;
  logic              o_ready;
  logic              o_error;
  logic [NS-1:0]     o_slave_enable;
  logic              o_slave_rw;
  logic [31:0]       o_slave_address;
  logic [31:0]       o_slave_wdata;
  logic [31:0]       srd [NS];
  logic [NS*32-1:0]  w_srd;
  logic [NS-1:0]     sr;

  assign w_srd = {srd[3], srd[2], srd[1], srd[0]};

  bus_router #(
    .SLAVES    (NS),
    .DATA_W    (32),
    .SLAVE_BASE(BASES),
    .SLAVE_MASK(MASKS),
    .TIMEOUT   (TMO)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (i_reset_n),
    .i_request      (i_request),
    .i_rw           (i_rw),
    .i_address      (i_address),
    .i_wdata        (i_wdata),
    .o_rdata        (o_rdata),
    .o_ready        (o_ready),
    .o_error        (o_error),
    .o_slave_enable (o_slave_enable),
    .o_slave_rw     (o_slave_rw),
    .o_slave_address(o_slave_address),
    .o_slave_wdata  (o_slave_wdata),
    .i_slave_rdata  (w_srd),
    .i_slave_ready  (sr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address map as seen by the master.
  function automatic logic [31:0] base_of(input int i);
    case (i)
      0:       return 32'h00000000;
      1:       return 32'h00010000;
      2:       return 32'h00000000;
      default: return 32'h50000000;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    case (i)
      0:       return 32'hFFFF0000;
      1:       return 32'hFFFF0000;
      2:       return 32'hFF000000;
      default: return 32'hF0000000;
    endcase
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & mask_of(i)) == base_of(i)) return i;
    end
    return -1;
  endfunction

  // Expected outputs after the coming rising edge.
  bit          chk_on = 1'b0;
  logic [3:0]  exp_en;
  logic        exp_ready;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic [31:0] exp_off;
  logic        exp_rw;
  logic [31:0] exp_wdata;

  // Observations for the directed literal checks.
  int          cyc = 0;
  int          t_req;
  int          obs_edges;
  logic        obs_err;
  logic [31:0] obs_rdata;
  logic [3:0]  obs_en;
  logic [31:0] obs_off;
  logic        obs_rw;
  logic [31:0] obs_wdata;
  logic        prev_ready = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #2;
    if (chk_on) begin
      chk("ready", 32'(o_ready), 32'(exp_ready));
      chk("slave_enable", 32'(o_slave_enable), 32'(exp_en));
      if (exp_en != 4'b0) begin
        chk("slave_address", o_slave_address, exp_off);
        chk("slave_rw", 32'(o_slave_rw), 32'(exp_rw));
        chk("slave_wdata", o_slave_wdata, exp_wdata);
      end
      if (exp_ready) begin
        chk("error", 32'(o_error), 32'(exp_err));
        chk("rdata", o_rdata, exp_rdata);
      end
    end
    if (o_slave_enable != 4'b0) begin
      obs_en    = o_slave_enable;
      obs_off   = o_slave_address;
      obs_rw    = o_slave_rw;
      obs_wdata = o_slave_wdata;
    end
    if (o_ready && !prev_ready) begin
      obs_edges = cyc - t_req;
      obs_err   = o_error;
      obs_rdata = o_rdata;
    end
    prev_ready = o_ready;
  end

  // One transaction. d = edge (after acceptance) at which the selected slave
  // first shows ready; d < 0 means never. abort_k > 0 pulls reset at that
  // cycle of the access instead of completing it.
  task automatic run_txn(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                         input int d, input int hold, input bit fix,
                         input logic [31:0] fix_rd, input int abort_k);
    int          sel;
    int          lat;
    int          last;
    bit          err;
    bit          hang;
    logic [31:0] exp_rd;
    sel    = decode(addr);
    err    = 1'b0;
    hang   = 1'b0;
    exp_rd = '0;
    if (sel < 0) begin
      lat = 0;
      err = 1'b1;
    end else begin
`ifdef BUS_ROUTER_TIMEOUT_EN
      if (d < 0 || d > TMO) begin
        lat = TMO;
        err = 1'b1;
      end else begin
        lat = d;
      end
`else
      if (d < 0) begin
        lat  = 0;
        hang = 1'b1;
      end else begin
        lat = d;
      end
`endif
    end
    if (hang && abort_k == 0) abort_k = 100;
    last      = hang ? 100 : lat + hold + 1;
    obs_edges = -1;
    obs_en    = '0;
    obs_off   = '0;
    obs_rw    = 1'b0;
    obs_wdata = '0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (abort_k > 0 && k == abort_k) begin
        chk_on    = 1'b0;
        i_reset_n = 1'b0;
        #1;
        chk("abort_enable", 32'(o_slave_enable), 32'h0);
        chk("abort_ready", 32'(o_ready), 32'h0);
        chk("abort_error", 32'(o_error), 32'h0);
        chk("abort_rdata", o_rdata, 32'h0);
        chk("abort_address", o_slave_address, 32'h0);
        chk("abort_wdata", o_slave_wdata, 32'h0);
        chk("abort_rw", 32'(o_slave_rw), 32'h0);
        i_request = 1'b0;
        sr        = '0;
        exp_en    = '0;
        exp_ready = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b1;
        chk_on    = 1'b1;
        return;
      end
      if (k == 0) begin
        i_request = 1'b1;
        i_rw      = rw;
        i_address = addr;
        i_wdata   = wd;
        t_req     = cyc + 1;
      end else begin
        // Ignored outside IDLE: scramble them.
        i_rw      = 1'($urandom);
        i_address = $urandom;
        i_wdata   = $urandom;
      end
      for (int i = 0; i < NS; i++) begin
        srd[i] = $urandom;
        sr[i]  = 1'($urandom);
      end
      if (sel >= 0) begin
        if (fix) srd[sel] = fix_rd;
        sr[sel] = (d >= 0 && k >= 1 && k >= d);
      end
      if (k == last) begin
        i_request = 1'b0;
        exp_en    = '0;
        exp_ready = 1'b0;
      end else if (hang || k < lat) begin
        exp_en    = 4'b1 << sel;
        exp_ready = 1'b0;
        exp_off   = addr - base_of(sel);
        exp_rw    = rw;
        exp_wdata = wd;
      end else begin
        if (k == lat && !err) exp_rd = srd[sel];
        exp_en    = '0;
        exp_ready = 1'b1;
        exp_err   = err;
        exp_rdata = err ? 32'h0 : exp_rd;
      end
    end
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    i_reset_n = 1'b0;
    i_request = 1'b0;
    i_rw      = 1'b0;
    i_address = '0;
    i_wdata   = '0;
    sr        = '0;
    for (int i = 0; i < NS; i++) srd[i] = '0;
    exp_en    = '0;
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = '0;
    #3;
    chk("reset_ready", 32'(o_ready), 32'h0);
    chk("reset_error", 32'(o_error), 32'h0);
    chk("reset_enable", 32'(o_slave_enable), 32'h0);
    chk("reset_rdata", o_rdata, 32'h0);
    chk("reset_address", o_slave_address, 32'h0);
    @(negedge clk);
    i_reset_n = 1'b1;
    chk_on    = 1'b1;

    // Read from slave 1 with three-cycle slave latency.
    run_txn(32'h00010024, 1'b0, 32'h0, 3, 1, 1'b1, 32'hDEADBEEF, 0);
    chk("read_latency", 32'(obs_edges + 1), 32'd4);
    chk("read_rdata", obs_rdata, 32'hDEADBEEF);
    chk("read_error", 32'(obs_err), 32'h0);
    chk("read_enable", 32'(obs_en), 32'h2);
    chk("read_offset", obs_off, 32'h24);

    // Write to slave 3, ready on the first access edge.
    run_txn(32'h50000010, 1'b1, 32'h12345678, 1, 0, 1'b0, 32'h0, 0);
    chk("write_latency", 32'(obs_edges + 1), 32'd2);
    chk("write_rw", 32'(obs_rw), 32'h1);
    chk("write_wdata", obs_wdata, 32'h12345678);
    chk("write_enable", 32'(obs_en), 32'h8);
    chk("write_error", 32'(obs_err), 32'h0);

    // Unmapped.
    run_txn(32'h30000000, 1'b0, 32'h0, 1, 2, 1'b0, 32'h0, 0);
    chk("unmapped_latency", 32'(obs_edges + 1), 32'd1);
    chk("unmapped_error", 32'(obs_err), 32'h1);
    chk("unmapped_rdata", obs_rdata, 32'h0);
    chk("unmapped_enable", 32'(obs_en), 32'h0);

`ifdef BUS_ROUTER_TIMEOUT_EN
    run_txn(32'h00010000, 1'b0, 32'h0, -1, 1, 1'b0, 32'h0, 0);
    chk("timeout_edges", 32'(obs_edges), 32'd8);
    chk("timeout_error", 32'(obs_err), 32'h1);
    chk("timeout_rdata", obs_rdata, 32'h0);
    // Ready on the timeout edge wins.
    run_txn(32'h00010000, 1'b0, 32'h0, 8, 0, 1'b1, 32'hCAFE0008, 0);
    chk("tie_edges", 32'(obs_edges), 32'd8);
    chk("tie_error", 32'(obs_err), 32'h0);
    chk("tie_rdata", obs_rdata, 32'hCAFE0008);
`else
    run_txn(32'h00010000, 1'b0, 32'h0, -1, 0, 1'b0, 32'h0, 100);
    chk("hang_no_ready", 32'(obs_edges), 32'hFFFFFFFF);
`endif

    // Overlapping windows: slaves 0 and 2 both match.
    run_txn(32'h00000100, 1'b0, 32'h0, 4, 0, 1'b1, 32'h0BAD0100, 0);
    chk("overlap_enable", 32'(obs_en), 32'h1);
    chk("overlap_rdata", obs_rdata, 32'h0BAD0100);
    chk("overlap_offset", obs_off, 32'h100);

    // Reset mid-access, then a normal transaction.
    run_txn(32'h00010008, 1'b0, 32'h0, 6, 0, 1'b0, 32'h0, 2);
    run_txn(32'h00010010, 1'b0, 32'h0, 2, 0, 1'b1, 32'h600D0010, 0);
    chk("post_reset_latency", 32'(obs_edges + 1), 32'd3);
    chk("post_reset_rdata", obs_rdata, 32'h600D0010);
    chk("post_reset_error", 32'(obs_err), 32'h0);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 4));
      case (r)
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {16'h0001, 16'($urandom)};
        2:       a = {8'h00, 24'($urandom)};
        3:       a = {4'h5, 28'($urandom)};
        default: a = $urandom;
      endcase
`ifdef BUS_ROUTER_TIMEOUT_EN
      run_txn(a, 1'($urandom), $urandom, int'($urandom_range(1, 10)),
              int'($urandom_range(0, 2)), 1'b0, 32'h0, 0);
`else
      run_txn(a, 1'($urandom), $urandom, int'($urandom_range(1, 6)),
              int'($urandom_range(0, 2)), 1'b0, 32'h0, 0);
`endif
    end

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
